// File: rtl/seg_scan_if.sv
// seg_scan_if: bundles the receive strobe/byte and the display drive lines
// of the 7-segment scan controller. The slave modport is the controller side.
interface seg_scan_if;
  logic       rx_sig;
  logic [7:0] rdata;
  logic [7:0] led_data;
  logic [5:0] led_sel;

  modport master (
    output rx_sig,
    output rdata,
    input  led_data,
    input  led_sel
  );

  modport slave (
    input  rx_sig,
    input  rdata,
    output led_data,
    output led_sel
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 6-digit common-anode 7-segment scan controller.
// Received bytes shift hex digits into a 6-entry buffer (entry 5 newest);
// the shared segment bus is time-multiplexed over the digits, each slot
// starting with an all-off blank interval to prevent ghosting.
// Optional build macro SEG_ZERO_SUPPRESS_EN enables leading-zero suppression.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  seg_scan_if.slave  seg
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t           state_p0, state_d;
  logic [CNT_W-1:0] cnt_p0, cnt_d;
  logic [2:0]       idx_p0, idx_d;

  logic [5:0]       vld_p0;
  logic [3:0]       nib_p0 [6];
  logic [5:0]       blank_d;

  logic [7:0]       led_data_p1, led_data_d;
  logic [5:0]       led_sel_p1, led_sel_d;

  logic             wr_en;
  logic             clr_en;

  // Active-low segment pattern for one hex nibble, dp always off.
  function automatic logic [7:0] seg7(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      default: pat = 8'h8E;
    endcase
    return pat;
  endfunction

  assign wr_en  = seg.rx_sig && (seg.rdata != 8'hFF);
  assign clr_en = seg.rx_sig && (seg.rdata == 8'hFF);

  // ---- stage p0: receive buffer (valid flags are reset, nibbles are not) ----

  // Valid flags: shift in a set flag on a write, clear all on 0xFF.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= '0;
    end else if (clr_en) begin
      vld_p0 <= '0;
    end else if (wr_en) begin
      vld_p0 <= {1'b1, vld_p0[5:1]};
    end
  end

  // Digit nibbles: shift toward entry 0, newest low nibble lands in entry 5.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      for (int i = 0; i < 5; i++) begin
        nib_p0[i] <= nib_p0[i+1];
      end
      nib_p0[5] <= seg.rdata[3:0];
    end
  end

  // Per-digit blanking mask from leading-zero suppression (empty when disabled).
  always_comb begin
    blank_d = '0;
`ifdef SEG_ZERO_SUPPRESS_EN
    blank_d[0] = !vld_p0[0] || (nib_p0[0] == 4'h0);
    for (int i = 1; i < 5; i++) begin
      blank_d[i] = blank_d[i-1] && (!vld_p0[i] || (nib_p0[i] == 4'h0));
    end
    blank_d[5] = 1'b0;
`else
    blank_d = '0;
`endif
  end

  // Scan FSM state, slot counter and digit index registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= ST_BLANK;
      cnt_p0   <= '0;
      idx_p0   <= 3'd0;
    end else begin
      state_p0 <= state_d;
      cnt_p0   <= cnt_d;
      idx_p0   <= idx_d;
    end
  end

  // Next-state logic plus the output values for the upcoming cycle; outputs
  // are decoded from the next state so led_sel/led_data line up with the FSM.
  always_comb begin
    state_d    = state_p0;
    idx_d      = idx_p0;
    cnt_d      = cnt_p0 + CNT_W'(1);
    led_sel_d  = 6'b111111;
    led_data_d = 8'hFF;

    if (cnt_p0 == CNT_LAST) begin
      cnt_d = '0;
    end

    case (state_p0)
      ST_BLANK: begin
        if (cnt_p0 == BLANK_LAST) begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_p0 == CNT_LAST) begin
          state_d = ST_BLANK;
          idx_d   = (idx_p0 == 3'd5) ? 3'd0 : idx_p0 + 3'd1;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    if (state_d == ST_SHOW) begin
      for (int i = 0; i < 6; i++) begin
        if (idx_d == 3'(i)) begin
          led_sel_d[i] = 1'b0;
          if (vld_p0[i] && !blank_d[i]) begin
            led_data_d = seg7(nib_p0[i]);
          end
        end
      end
    end
  end

  // ---- stage p1: registered display outputs ----

  // Output registers: glitch-free drive of the segment and select lines.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      led_sel_p1  <= 6'b111111;
      led_data_p1 <= 8'hFF;
    end else begin
      led_sel_p1  <= led_sel_d;
      led_data_p1 <= led_data_d;
    end
  end

  assign seg.led_sel  = led_sel_p1;
  assign seg.led_data = led_data_p1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with SCAN_DIV=8,
// BLANK_CYC=2. k counts rising edges since reset release; outputs sampled
// 1 time unit after each edge reflect slot counter k%8, digit (k/8)%6.
module tb_seg_scan_ctrl;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   k        = 0;

  seg_scan_if bus ();

  seg_scan_ctrl #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .seg     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
    k++;
  endtask

  task automatic chk_sel(input string tag, input logic [5:0] exp);
    checks++;
    assert (bus.led_sel === exp) else begin
      failures++;
      $error("FAIL %s k=%0d led_sel got=%b want=%b", tag, k, bus.led_sel, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [7:0] exp);
    checks++;
    assert (bus.led_data === exp) else begin
      failures++;
      $error("FAIL %s k=%0d led_data got=%h want=%h", tag, k, bus.led_data, exp);
    end
  endtask

  task automatic wait_until(input int t);
    if (k > t) begin
      checks++;
      failures++;
      $error("FAIL schedule k=%0d already past target=%0d", k, t);
    end
    while (k < t) tick();
  endtask

  task automatic strobe(input logic [7:0] b);
    bus.rx_sig = 1'b1;
    bus.rdata  = b;
    tick();
    bus.rx_sig = 1'b0;
  endtask

  function automatic logic [5:0] exp_sel(input int kk);
    logic [5:0] one;
    one = 6'b000001;
    if ((kk % 8) < 2) return 6'b111111;
    return ~(one << ((kk / 8) % 6));
  endfunction

  initial begin
    logic [7:0] zero_exp;
`ifdef SEG_ZERO_SUPPRESS_EN
    zero_exp = 8'hFF;
`else
    zero_exp = 8'hC0;
`endif
    bus.rx_sig = 1'b0;
    bus.rdata  = 8'h00;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    chk_sel("reset_sel", 6'b111111);
    chk_data("reset_data", 8'hFF);
    rst_n = 1'b1;
    k = 0;

    // Idle scan: full frame, buffer empty
    chk_sel("idle_sel", exp_sel(0));
    for (int i = 1; i <= 48; i++) begin
      tick();
      chk_sel("idle_sel", exp_sel(k));
      chk_data("idle_data", 8'hFF);
    end

    // Load 01..06 back-to-back, check next frame
    strobe(8'h01);
    strobe(8'h02);
    strobe(8'h03);
    strobe(8'h04);
    strobe(8'h05);
    strobe(8'h06);
    wait_until(98);
    chk_sel("ld_d0_sel", 6'b111110); chk_data("ld_d0", 8'hF9);
    wait_until(106);
    chk_sel("ld_d1_sel", 6'b111101); chk_data("ld_d1", 8'hA4);
    wait_until(114);
    chk_sel("ld_d2_sel", 6'b111011); chk_data("ld_d2", 8'hB0);
    wait_until(122);
    chk_sel("ld_d3_sel", 6'b110111); chk_data("ld_d3", 8'h99);
    wait_until(130);
    chk_sel("ld_d4_sel", 6'b101111); chk_data("ld_d4", 8'h92);
    wait_until(138);
    chk_sel("ld_d5_sel", 6'b011111); chk_data("ld_d5", 8'h82);

    // 0x3A then 0xFF during digit 5 SHOW: live update, then clear
    wait_until(186);
    chk_data("live_pre", 8'h82);
    bus.rx_sig = 1'b1;
    bus.rdata  = 8'h3A;
    tick();
    chk_data("live_lat", 8'h82);
    bus.rdata = 8'hFF;
    tick();
    bus.rx_sig = 1'b0;
    chk_sel("live_sel", 6'b011111);
    chk_data("live_3a", 8'h88);
    tick();
    chk_data("live_clr", 8'hFF);
    wait_until(194);
    chk_sel("clr_d0_sel", 6'b111110);
    chk_data("clr_d0", 8'hFF);

    // Leading zeros: load 00,00,07
    strobe(8'h00);
    strobe(8'h00);
    strobe(8'h07);
    wait_until(258);
    chk_data("lz_d2", 8'hFF);
    wait_until(266);
    chk_sel("lz_d3_sel", 6'b110111); chk_data("lz_d3", zero_exp);
    wait_until(274);
    chk_data("lz_d4", zero_exp);
    wait_until(282);
    chk_data("lz_d5", 8'hF8);

    // Strobe on SHOW->BLANK edge between digit 1 and digit 2
    wait_until(303);
    chk_sel("bnd_pre_sel", 6'b111101);
    strobe(8'h05);
    chk_sel("bnd_blank_sel", 6'b111111);
    chk_data("bnd_blank_data", 8'hFF);
    wait_until(306);
    chk_sel("bnd_d2_sel", 6'b111011);
    chk_data("bnd_d2", zero_exp);
    wait_until(322);
    chk_data("bnd_d4", 8'hF8);
    wait_until(330);
    chk_sel("bnd_d5_sel", 6'b011111);
    chk_data("bnd_d5", 8'h92);

    // Asynchronous reset mid-SHOW of digit 3
    wait_until(364);
    chk_sel("ar_pre_sel", 6'b110111);
    chk_data("ar_pre_data", zero_exp);
    #2;
    rst_n = 1'b0;
    #1;
    chk_sel("ar_sel", 6'b111111);
    chk_data("ar_data", 8'hFF);
    tick();
    tick();
    rst_n = 1'b1;
    k = 0;
    chk_sel("rs_k0_sel", 6'b111111);
    wait_until(1);
    chk_sel("rs_k1_sel", 6'b111111);
    wait_until(2);
    chk_sel("rs_d0_sel", 6'b111110);
    chk_data("rs_d0", 8'hFF);
    wait_until(10);
    chk_sel("rs_d1_sel", 6'b111101);
    chk_data("rs_d1", 8'hFF);
    wait_until(45);
    chk_sel("rs_d5_sel", 6'b011111);
    chk_data("rs_d5", 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
